// File: rtl/line_window_gen.sv
// Line-buffered 3x3 window generator: turns a raster pixel stream of CHANNELS
// frames into stride-1, unpadded 3x3 windows tagged with channel/row/column.
module line_window_gen #(
   parameter int DATA_W   = 8,
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 32,
   parameter int CHANNELS = 3,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int ROW_W   = $clog2(IMG_H),
   localparam int COL_W   = $clog2(IMG_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_pixel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [9*DATA_W-1:0]   out_window,
   output logic [CH_W-1:0]       out_ch,
   output logic [ROW_W-1:0]      out_row,
   output logic [COL_W-1:0]      out_col,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never depends on ready, and ready may depend on valid.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

   state_t              state;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic [CH_W-1:0]     ch;
   logic [DATA_W-1:0]   lb0 [IMG_W];
   logic [DATA_W-1:0]   lb1 [IMG_W];
   logic [9*DATA_W-1:0] win_q;
   logic [9*DATA_W-1:0] next_win;
   logic                accept;
   logic                emit;
   logic                last_pix;

   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign emit      = (row >= ROW_W'(2)) && (col >= COL_W'(2));
   assign last_pix  = (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);
   assign dbg_state = state;

   // Window shifted one column left; the new right column comes from the
   // two line buffers (older row on top) and the incoming pixel.
   always_comb begin
      next_win = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 2; c++) begin
            next_win[DATA_W*(3*r+c) +: DATA_W] = win_q[DATA_W*(3*r+c+1) +: DATA_W];
         end
      end
      next_win[DATA_W*2 +: DATA_W] = lb1[col];
      next_win[DATA_W*5 +: DATA_W] = lb0[col];
      next_win[DATA_W*8 +: DATA_W] = in_pixel;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         win_q    <= next_win;
         lb1[col] <= lb0[col];
         lb0[col] <= in_pixel;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         ch         <= '0;
         out_valid  <= 1'b0;
         out_window <= '0;
         out_ch     <= '0;
         out_row    <= '0;
         out_col    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  col   <= '0;
                  row   <= '0;
                  ch    <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  if (col == COL_LAST) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        row <= '0;
                        ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
                  if (last_pix) begin
                     state <= DRAIN;
                     busy  <= 1'b0;
                  end
               end
               // col >= 2 guarantees all three columns belong to this row
               if (accept && emit) begin
                  out_valid  <= 1'b1;
                  out_window <= next_win;
                  out_ch     <= ch;
                  out_row    <= row - ROW_W'(2);
                  out_col    <= col - COL_W'(2);
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (!out_valid || out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
